// File: rtl/kbd_pkg.sv
// kbd_pkg: decoder state encoding, PS/2 set-2 scan-code constants and scan-to-ASCII lookup
package kbd_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXT   = 2'd1;
  localparam logic [1:0] ST_BREAK = 2'd2;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  // Returns 0x00 for unmapped codes; letters are upper-cased when up is set.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc, input logic up);
    logic [7:0] a;
    case (sc)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0A;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return (up && a >= "a" && a <= "z") ? a - 8'h20 : a;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises the PS/2 lines and assembles checked 11-bit frames into bytes
module ps2_rx #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]    r_clk_s;
  logic [2:0]    r_dat_s;
  logic [3:0]    r_cnt;
  logic [9:0]    r_sh;
  logic [TW-1:0] r_tmo;
  logic          w_fall;
  logic [10:0]   w_frame;
  logic          w_ok;
  assign w_fall  = r_clk_s[2] & ~r_clk_s[1];
  assign w_frame = {r_dat_s[2], r_sh};
  assign w_ok    = ~w_frame[0] & w_frame[10] & ^w_frame[9:1];
  // Three-flop synchronisers, idle-high after reset
  always_ff @(posedge clk) begin
    r_clk_s <= reset ? 3'b111 : {r_clk_s[1:0], i_ps2_clk};
    r_dat_s <= reset ? 3'b111 : {r_dat_s[1:0], i_ps2_data};
  end
  // Bit shifting, frame check on the 11th edge, and abandonment of stalled frames
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sh    <= '0;
      r_tmo   <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_byte  <= '0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        if (r_cnt == 4'd10) begin
          r_cnt   <= '0;
          o_valid <= w_ok;
          o_err   <= ~w_ok;
          if (w_ok) o_byte <= w_frame[8:1];
        end else begin
          r_cnt <= r_cnt + 4'd1;
          r_sh  <= {r_dat_s[2], r_sh[9:1]};
        end
      end else if (r_cnt != 4'd0) begin
        if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_cnt <= '0;
          r_tmo <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ps2_kbd_ascii.sv
// ps2_kbd_ascii: PS/2 keyboard to ASCII strobe (scan FIFO + make/break decoder); define KBD_SHIFT_EN for shift-aware uppercase
module ps2_kbd_ascii
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic          w_rx_valid;
  logic [7:0]    w_rx_byte;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop_ok;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_rd;
  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          w_up;
  logic [7:0]    w_ascii;
  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_valid   (w_rx_valid),
    .o_byte    (w_rx_byte),
    .o_err     (frame_err)
  );
  assign w_pop_ok = 1'b1;
  assign w_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_pop    = (r_cnt != '0) & w_pop_ok;
  assign w_push   = w_rx_valid & (~w_full | w_pop);
  assign w_rd     = r_mem[r_rp];
  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_rx_byte;
  end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      r_wp     <= r_wp + AW'(w_push);
      r_rp     <= r_rp + AW'(w_pop);
      r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      overflow <= overflow | (w_rx_valid & ~w_push);
    end
  end
`ifdef KBD_SHIFT_EN
  logic r_shift;
  assign w_up = r_shift;
  // Shift held state: make in IDLE sets it, break clears it
  always_ff @(posedge clk) begin
    if (reset) r_shift <= 1'b0;
    else if (w_pop && (w_rd == SC_LSHIFT || w_rd == SC_RSHIFT) && r_state != ST_EXT) r_shift <= r_state == ST_IDLE;
  end
`else
  assign w_up = 1'b0;
`endif
  assign w_ascii = (r_state == ST_IDLE) ? scan_to_ascii(w_rd, w_up) :
                   (r_state == ST_EXT && w_rd == SC_ENTER) ? 8'h0A : 8'h00;
  assign w_next  = (r_state == ST_IDLE && w_rd == SC_EXT) ? ST_EXT :
                   (r_state != ST_BREAK && w_rd == SC_BREAK) ? ST_BREAK : ST_IDLE;
  // Decoder: one byte per cycle, registered strobe and held ASCII
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      key_valid <= 1'b0;
      key_ascii <= 8'h00;
    end else begin
      key_valid <= w_pop & (w_ascii != 8'h00);
      if (w_pop) r_state <= w_next;
      if (w_pop && w_ascii != 8'h00) key_ascii <= w_ascii;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// tb_ps2_kbd_ascii: scoreboard bench driving PS/2 frames and checking ASCII strobes
`timescale 1ns/1ps
module tb_ps2_kbd_ascii;
  localparam int DEPTH = 4;
  localparam int TMO   = 200;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       frame_err;
  logic       overflow;
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_ferr = 0;
  int         ferr0;
  ps2_kbd_ascii #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_ascii(key_ascii),
    .key_valid(key_valid),
    .frame_err(frame_err),
    .overflow (overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad, input logic lat, input int nb);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (lat && i == 10 && k == 4) chk("lat_early", key_valid, 0);
        if (lat && i == 10 && k == 5) chk("lat_hit", key_valid, 1);
      end
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask
  always @(negedge clk) begin
    if (!reset && frame_err) n_ferr++;
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) chk("spurious", {24'd0, key_ascii}, 32'hFFFF_FFFF);
      else chk("ascii", key_ascii, exp_q.pop_front());
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ascii", key_ascii, 8'h00);
    chk("rst_valid", key_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h61);
    key(8'h1C); key(8'hF0); key(8'h1C);
    repeat (10) @(negedge clk);
    ferr0 = n_ferr;
    send_frame(8'h5A, 1'b1, 1'b0, 11);
    repeat (10) @(negedge clk);
    chk("par_ferr", n_ferr - ferr0, 1);
    chk("par_empty", 32'(dut.r_cnt), 0);
    exp_q.push_back(8'h0A);
    key(8'hE0); key(8'h5A);
    key(8'hE0); key(8'h1C);
    key(8'h76);
    key(8'hE0); key(8'hF0); key(8'h5A);
    exp_q.push_back(8'h61); exp_q.push_back(8'h61);
    key(8'h1C); key(8'h1C);
    exp_q.push_back(8'h20); exp_q.push_back(8'h08); exp_q.push_back(8'h30); exp_q.push_back(8'h7A);
    key(8'h29); key(8'h66); key(8'h45); key(8'h1A);
`ifdef KBD_SHIFT_EN
    exp_q.push_back(8'h41); exp_q.push_back(8'h61);
`else
    exp_q.push_back(8'h61); exp_q.push_back(8'h61);
`endif
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    repeat (10) @(negedge clk);
    chk("ovf_pre", overflow, 0);
    force dut.w_pop_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h31);
    for (int i = 0; i <= DEPTH; i++) key(8'h16);
    repeat (5) @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_full", 32'(dut.r_cnt), DEPTH);
    release dut.w_pop_ok;
    repeat (20) @(negedge clk);
    chk("ovf_drain", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);
    ferr0 = n_ferr;
    send_frame(8'h00, 1'b0, 1'b0, 5);
    repeat (TMO + 1) @(negedge clk);
    exp_q.push_back(8'h20);
    key(8'h29);
    repeat (10) @(negedge clk);
    chk("tmo_ferr", n_ferr - ferr0, 0);
    chk("tmo_drain", exp_q.size(), 0);
    send_frame(8'h1C, 1'b0, 1'b0, 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_ascii", key_ascii, 8'h00);
    chk("rst2_ovf", overflow, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h32);
    key(8'h1E);
    repeat (30) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
